vga_sync_detector: RTL and testbench

//  Receive-side counterpart of the VGA timing generator. Samples incoming HSync/VSync
//  (active-low pulses), measures line/frame timing, and declares lock after stable frames.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_edge_detect.sv | 36 +++
 rtl/vga_sync_detector.sv | 187 ++++++++++++++++++
 tb/tb_vga_sync_detector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared XGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster constants and the
//   sync detector FSM state encoding. Used by both the timing generator and the
//   receive-side sync detector so the active window is defined in one place.
package vga_timing_pkg;

    localparam int unsigned HPIXELS = 1344;  // clocks per line
    localparam int unsigned VLINES  = 806;   // lines per frame
    localparam int unsigned HBP     = 296;   // active when HCount > HBP
    localparam int unsigned HFP     = 1320;  // active when HCount < HFP
    localparam int unsigned VBP     = 35;    // active when VCount > VBP
    localparam int unsigned VFP     = 803;   // active when VCount < VFP
    localparam int unsigned HSP     = 136;   // HSync low width, clocks
    localparam int unsigned VSP     = 6;     // VSync low width, lines

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// vga_edge_detect
//   Registers one incoming sync line and produces single-cycle fall/rise pulses
//   from the registered value and its one-cycle-delayed copy.
// Ports
//   CLK_65MHz  in   pixel clock
//   Clear      in   synchronous active-high reset
//   sync_raw   in   raw sync input (low = pulse)
//   fall       out  prev & ~sync_q
//   rise       out  ~prev & sync_q
module vga_edge_detect (
    input  logic CLK_65MHz,
    input  logic Clear,
    input  logic sync_raw,
    output logic fall,
    output logic rise
);

    logic sync_q;
    logic prev_q;

    // Reset to the idle (high) level so leaving reset with an idle input
    // produces no spurious edge.
    always_ff @(posedge CLK_65MHz) begin
        if (Clear) begin
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_raw;
            prev_q <= sync_q;
        end
    end

    assign fall = prev_q & ~sync_q;
    assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/vga_sync_detector.sv
// vga_sync_detector
//   Receive-side counterpart of the VGA timing generator. Measures incoming
//   line/frame timing, declares lock after LOCK_FRAMES consecutive matching
//   frames, and regenerates HCount/VCount/VideoOn aligned to the source
//   (2 clocks behind it).
// Ports
//   CLK_65MHz   in   pixel clock
//   Clear       in   synchronous active-high reset
//   HSync_in    in   horizontal sync, low = pulse
//   VSync_in    in   vertical sync, low = pulse
//   Locked      out  timing stable (registered)
//   VideoOn     out  recovered active-video flag, gated by Locked
//   FrameStart  out  1-cycle pulse on each VSync falling edge
//   HCount      out  recovered pixel index
//   VCount      out  recovered line index
//   HTotal      out  last measured line length, clocks
//   VTotal      out  last measured frame length, lines
//   HSyncWidth  out  last HSync low width, clocks
//   VSyncWidth  out  last VSync low width, lines
module vga_sync_detector #(
    parameter int unsigned CW          = 17,
    parameter int unsigned HBP         = vga_timing_pkg::HBP,
    parameter int unsigned HFP         = vga_timing_pkg::HFP,
    parameter int unsigned VBP         = vga_timing_pkg::VBP,
    parameter int unsigned VFP         = vga_timing_pkg::VFP,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_TIMEOUT   = 4095
) (
    input  logic          CLK_65MHz,
    input  logic          Clear,
    input  logic          HSync_in,
    input  logic          VSync_in,
    output logic          Locked,
    output logic          VideoOn,
    output logic          FrameStart,
    output logic [CW-1:0] HCount,
    output logic [CW-1:0] VCount,
    output logic [CW-1:0] HTotal,
    output logic [CW-1:0] VTotal,
    output logic [CW-1:0] HSyncWidth,
    output logic [CW-1:0] VSyncWidth
);

    import vga_timing_pkg::*;

    localparam int unsigned MW = $clog2(LOCK_FRAMES + 1);

    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW-1:0] H_TIMEOUT_C = CW'(H_TIMEOUT);
    localparam logic [CW-1:0] HBP_C       = CW'(HBP);
    localparam logic [CW-1:0] HFP_C       = CW'(HFP);
    localparam logic [CW-1:0] VBP_C       = CW'(VBP);
    localparam logic [CW-1:0] VFP_C       = CW'(VFP);
    localparam logic [MW-1:0] MATCH_ONE   = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] LOCK_TARGET = MW'(LOCK_FRAMES);

    logic hs_fall, hs_rise, vs_fall, vs_rise;

    vga_edge_detect u_hs_edge (
        .CLK_65MHz (CLK_65MHz),
        .Clear     (Clear),
        .sync_raw  (HSync_in),
        .fall      (hs_fall),
        .rise      (hs_rise)
    );

    vga_edge_detect u_vs_edge (
        .CLK_65MHz (CLK_65MHz),
        .Clear     (Clear),
        .sync_raw  (VSync_in),
        .fall      (vs_fall),
        .rise      (vs_rise)
    );

    logic [CW-1:0] h_cnt_q, v_cnt_q;
    logic [CW-1:0] h_plus1, v_plus1;
    logic          h_mis, v_mis, line_bad, h_timeout, lock_lost;

    sync_state_e   state_q;
    logic [MW-1:0] match_cnt_q;
    logic [MW-1:0] match_inc;
    logic          ref_valid_q;
    logic          line_mm_q;

    assign h_plus1   = h_cnt_q + CNT_ONE;
    assign v_plus1   = v_cnt_q + CNT_ONE;
    assign h_mis     = hs_fall & (h_plus1 != HTotal);
    assign v_mis     = vs_fall & (v_plus1 != VTotal);
    // A mismatching last line coincides with the frame-start vs_fall, so it
    // still counts against the frame being closed.
    assign line_bad  = line_mm_q | h_mis;
    assign h_timeout = (h_cnt_q == H_TIMEOUT_C);
    assign lock_lost = h_mis | v_mis | h_timeout;
    assign match_inc = match_cnt_q + MATCH_ONE;

    // Counters and measurements
    always_ff @(posedge CLK_65MHz) begin
        if (Clear) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            HTotal     <= '0;
            VTotal     <= '0;
            HSyncWidth <= '0;
            VSyncWidth <= '0;
        end else begin
            if (hs_fall) begin
                h_cnt_q <= '0;
            end else if (h_cnt_q != CNT_MAX) begin
                h_cnt_q <= h_plus1;
            end

            // vs_fall wins over a coincident hs_fall
            if (vs_fall) begin
                v_cnt_q <= '0;
            end else if (hs_fall && (v_cnt_q != CNT_MAX)) begin
                v_cnt_q <= v_plus1;
            end

            if (hs_fall) HTotal     <= h_plus1;
            if (hs_rise) HSyncWidth <= h_plus1;
            if (vs_fall) VTotal     <= v_plus1;
            if (vs_rise) VSyncWidth <= v_plus1;
        end
    end

    // Lock FSM
    always_ff @(posedge CLK_65MHz) begin
        if (Clear) begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
            ref_valid_q <= 1'b0;
            line_mm_q   <= 1'b0;
            Locked      <= 1'b0;
        end else begin
            if (vs_fall) begin
                line_mm_q <= 1'b0;
            end else if (h_mis) begin
                line_mm_q <= 1'b1;
            end

            unique case (state_q)
                SEARCH: begin
                    // First vs_fall closes a partial frame; discard it.
                    if (vs_fall) begin
                        state_q     <= MEASURE;
                        match_cnt_q <= '0;
                        ref_valid_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (vs_fall) begin
                        if (!ref_valid_q) begin
                            ref_valid_q <= 1'b1;
                            match_cnt_q <= '0;
                        end else if (!v_mis && !line_bad) begin
                            match_cnt_q <= match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state_q <= LOCKED;
                                Locked  <= 1'b1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_lost) begin
                        state_q <= SEARCH;
                        Locked  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                    Locked  <= 1'b0;
                end
            endcase
        end
    end

    assign HCount     = h_cnt_q;
    assign VCount     = v_cnt_q;
    assign FrameStart = vs_fall;
    assign VideoOn    = Locked & (HCount > HBP_C) & (HCount < HFP_C) &
                        (VCount > VBP_C) & (VCount < VFP_C);

endmodule

// File: tb/tb_vga_sync_detector.sv
// tb_vga_sync_detector
//   Directed bench for vga_sync_detector. A small raster (40 x 12, sync
//   widths 5/2) stands in for the XGA source so multi-frame lock sequences
//   stay short; the DUT window/timeout parameters are scaled to match.
module tb_vga_sync_detector;

    localparam int unsigned CW    = 10;
    localparam int          HTOT  = 40;
    localparam int          VTOT  = 12;
    localparam int          HSW   = 5;
    localparam int          VSW   = 2;
    localparam int          FRAME = HTOT * VTOT;

    logic          CLK_65MHz = 1'b0;
    logic          Clear;
    logic          HSync_in;
    logic          VSync_in;
    logic          Locked;
    logic          VideoOn;
    logic          FrameStart;
    logic [CW-1:0] HCount, VCount, HTotal, VTotal, HSyncWidth, VSyncWidth;

    always #5 CLK_65MHz = ~CLK_65MHz;

    vga_sync_detector #(
        .CW          (CW),
        .HBP         (8),
        .HFP         (36),
        .VBP         (3),
        .VFP         (11),
        .LOCK_FRAMES (2),
        .H_TIMEOUT   (200)
    ) dut (
        .CLK_65MHz  (CLK_65MHz),
        .Clear      (Clear),
        .HSync_in   (HSync_in),
        .VSync_in   (VSync_in),
        .Locked     (Locked),
        .VideoOn    (VideoOn),
        .FrameStart (FrameStart),
        .HCount     (HCount),
        .VCount     (VCount),
        .HTotal     (HTotal),
        .VTotal     (VTotal),
        .HSyncWidth (HSyncWidth),
        .VSyncWidth (VSyncWidth)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Source position now (cur), one step ago (d1) and two steps ago (d2).
    int cur_h = -1, cur_v = -1, d1_h = -1, d1_v = -1, d2_h = -1, d2_v = -1;
    int line_len = HTOT;
    int vs_evt   = 0;
    bit gen_en = 1'b0, short_req = 1'b0, vs_now = 1'b0, lk_now = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the source model and drive the sync inputs.
    task automatic step();
        @(posedge CLK_65MHz);
        #1;
        d2_h = d1_h;
        d2_v = d1_v;
        d1_h = cur_h;
        d1_v = cur_v;
        if (gen_en) begin
            if (cur_h < 0) begin
                cur_h    = 0;
                cur_v    = 0;
                line_len = HTOT;
            end else begin
                cur_h++;
                if (cur_h >= line_len) begin
                    cur_h     = 0;
                    cur_v     = (cur_v == VTOT - 1) ? 0 : cur_v + 1;
                    line_len  = short_req ? HTOT - 4 : HTOT;
                    short_req = 1'b0;
                end
            end
            HSync_in = !(cur_h < HSW);
            VSync_in = !(cur_v < VSW);
        end else begin
            cur_h    = -1;
            cur_v    = -1;
            HSync_in = 1'b1;
            VSync_in = 1'b1;
        end
        // vs_fall is visible one step after the source frame start, Locked one more.
        vs_now = (d1_h == 0) && (d1_v == 0);
        lk_now = (d2_h == 0) && (d2_v == 0);
        if (vs_now) vs_evt++;
    endtask

    task automatic wait_cur(input string tag, input int h, input int v);
        bit found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            step();
            if (cur_h == h && cur_v == v) found = 1'b1;
        end
        check({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(Locked), 32'd0);
        check({tag, "_video"}, 32'(VideoOn), 32'd0);
        check({tag, "_fstart"}, 32'(FrameStart), 32'd0);
        check({tag, "_hcount"}, 32'(HCount), 32'd0);
        check({tag, "_vcount"}, 32'(VCount), 32'd0);
        check({tag, "_htotal"}, 32'(HTotal), 32'd0);
        check({tag, "_vtotal"}, 32'(VTotal), 32'd0);
        check({tag, "_hswidth"}, 32'(HSyncWidth), 32'd0);
        check({tag, "_vswidth"}, 32'(VSyncWidth), 32'd0);
    endtask

    // Expect lock exactly one clock after the 4th vs_fall from now.
    task automatic relock(input string tag, input bit meas);
        bit done = 1'b0;
        vs_evt = 0;
        for (int n = 0; n < 6 * FRAME && !done; n++) begin
            step();
            if (meas && lk_now && vs_evt == 2) begin
                check({tag, "_htotal"}, 32'(HTotal), 32'(HTOT));
                check({tag, "_vtotal"}, 32'(VTotal), 32'(VTOT));
                check({tag, "_hswidth"}, 32'(HSyncWidth), 32'(HSW));
                check({tag, "_vswidth"}, 32'(VSyncWidth), 32'(VSW));
            end
            if (vs_now && vs_evt == 4) check({tag, "_pre"}, 32'(Locked), 32'd0);
            if (lk_now && vs_evt == 4) begin
                check(tag, 32'(Locked), 32'd1);
                done = 1'b1;
            end
        end
        check({tag, "_bound"}, 32'(done), 32'd1);
    endtask

    // VideoOn window boundaries: source (h, v) two steps back -> expected VideoOn
    int win_h [8] = '{8, 9, 35, 36, 20, 20, 20, 20};
    int win_v [8] = '{4, 4, 4, 4, 3, 10, 11, 4};
    int win_e [8] = '{0, 1, 1, 0, 0, 1, 0, 1};

    initial begin
        Clear    = 1'b1;
        HSync_in = 1'b1;
        VSync_in = 1'b1;
        repeat (4) step();
        check_all_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'(vga_timing_pkg::SEARCH));

        // 1: lock from reset
        Clear  = 1'b0;
        gen_en = 1'b1;
        relock("t1_lock", 1'b1);

        // 5/6: window boundaries and frame-start alignment over one locked frame
        for (int n = 0; n < FRAME + 4; n++) begin
            step();
            for (int i = 0; i < 8; i++) begin
                if (d2_h == win_h[i] && d2_v == win_v[i]) begin
                    check($sformatf("t5_h%0d_v%0d", win_h[i], win_v[i]),
                          32'(VideoOn), 32'(win_e[i]));
                    check($sformatf("t5_hcount_%0d", win_h[i]), 32'(HCount), 32'(win_h[i]));
                end
            end
            if (vs_now) begin
                check("t6_fstart", 32'(FrameStart), 32'd1);
                check("t6_pre_hcount", 32'(HCount), 32'(HTOT - 1));
                check("t6_pre_vcount", 32'(VCount), 32'(VTOT - 1));
            end
            if (lk_now) begin
                check("t6_hcount", 32'(HCount), 32'd0);
                check("t6_vcount", 32'(VCount), 32'd0);
                check("t6_fstart_end", 32'(FrameStart), 32'd0);
                check("t6_locked", 32'(Locked), 32'd1);
            end
        end

        // 2: one short line drops lock
        wait_cur("t2_arm", 0, 4);
        short_req = 1'b1;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < FRAME && !seen; n++) begin
                step();
                if (d1_h == 0 && d1_v == 6) seen = 1'b1;
            end
            check("t2_reach", 32'(seen), 32'd1);
        end
        check("t2_pre_locked", 32'(Locked), 32'd1);
        step();
        check("t2_locked", 32'(Locked), 32'd0);
        check("t2_video", 32'(VideoOn), 32'd0);
        check("t2_state", 32'(dut.state_q), 32'(vga_timing_pkg::SEARCH));
        relock("t2_relock", 1'b0);

        // 3: HSync stuck high -> timeout, then saturation
        wait_cur("t3_arm", 10, 5);
        gen_en = 1'b0;
        for (int j = 1; j < 192; j++) step();
        step();
        check("t3_hcount_to", 32'(HCount), 32'd200);
        check("t3_locked_to", 32'(Locked), 32'd1);
        step();
        check("t3_hcount_after", 32'(HCount), 32'd201);
        check("t3_locked", 32'(Locked), 32'd0);
        check("t3_state", 32'(dut.state_q), 32'(vga_timing_pkg::SEARCH));
        for (int j = 194; j <= 1015; j++) step();
        check("t3_sat", 32'(HCount), 32'd1023);
        repeat (10) step();
        check("t3_sat_hold", 32'(HCount), 32'd1023);
        gen_en = 1'b1;
        relock("t3_relock", 1'b0);

        // 4: Clear mid-frame while locked
        wait_cur("t4_arm", 20, 5);
        check("t4_pre_video", 32'(VideoOn), 32'd1);
        Clear = 1'b1;
        step();
        check_all_zero("t4_clear");
        step();
        Clear = 1'b0;
        relock("t4_relock", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
